// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor.
// Provides the table index and partial-tag extraction functions, the stored
// target width, and the direction-counter constants (reset, allocate, max).
// All helpers take the table geometry as arguments so every instance can use
// its own parameters.
package bp_pkg;

  localparam int ADDR_W = 32;
  // Targets are word-aligned, so bits [1:0] are never stored.
  localparam int TGT_W  = ADDR_W - 2;

  function automatic logic [ADDR_W-1:0] pc_index(input logic [ADDR_W-1:0] pc,
                                                 input int idx_bits);
    return (pc >> 2) & ((32'd1 << idx_bits) - 32'd1);
  endfunction

  function automatic logic [ADDR_W-1:0] pc_tag(input logic [ADDR_W-1:0] pc,
                                               input int idx_bits,
                                               input int tag_bits);
    return (pc >> (idx_bits + 2)) & ((32'd1 << tag_bits) - 32'd1);
  endfunction

  // Weakly not-taken; evaluates to 0 for a 1-bit counter.
  function automatic int ctr_rst_val(input int ctr_bits);
    return (1 << (ctr_bits - 1)) - 1;
  endfunction

  // Weakly taken, used when a taken branch allocates an entry.
  function automatic int ctr_alloc_val(input int ctr_bits);
    return 1 << (ctr_bits - 1);
  endfunction

  function automatic int ctr_max_val(input int ctr_bits);
    return (1 << ctr_bits) - 1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Up/down saturating direction counter with a load for entry allocation.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (to weakly not-taken)
//   load      - force the weakly-taken allocation value (highest priority)
//   inc, dec  - step up / down, saturating at max / 0
//   count     - current counter value; its MSB is the taken prediction
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                inc,
  input  logic                dec,
  output logic [CTR_BITS-1:0] count
);

  localparam logic [CTR_BITS-1:0] RST_VAL   = CTR_BITS'(ctr_rst_val(CTR_BITS));
  localparam logic [CTR_BITS-1:0] ALLOC_VAL = CTR_BITS'(ctr_alloc_val(CTR_BITS));
  localparam logic [CTR_BITS-1:0] MAX_VAL   = CTR_BITS'(ctr_max_val(CTR_BITS));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= ALLOC_VAL;
    end else if (inc && (count != MAX_VAL)) begin
      count <= count + 1'b1;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with a saturating-counter BHT.
// Looked up with the IF fetch address; the result is registered so it lines
// up with the instruction word in ID. Trained from resolved control flow in EX.
// Optional feature macro: BP_GSHARE_EN (global history XORed into the index).
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   bp_enable           - 0 suppresses id_pred_taken; training continues
//   if_pc, if_stall     - fetch address; hold the ID prediction when stalled
//   id_pred_hit/taken/target - registered prediction for the instruction in ID
//   ex_upd_*            - resolved branch/jump training port
//   stat_branches/mispreds   - free-running wrap-around statistics
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 10,
  parameter int CTR_BITS = 2,
  parameter int GHR_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bp_enable,
  input  logic [31:0] if_pc,
  input  logic        if_stall,
  output logic        id_pred_hit,
  output logic        id_pred_taken,
  output logic [31:0] id_pred_target,
  input  logic        ex_upd_valid,
  input  logic [31:0] ex_upd_pc,
  input  logic        ex_upd_taken,
  input  logic [31:0] ex_upd_target,
  input  logic        ex_upd_mispred,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispreds
);

  localparam int IDX_BITS = $clog2(ENTRIES);

  if ((ENTRIES < 4) || ((1 << IDX_BITS) != ENTRIES) || (CTR_BITS < 1) ||
      (CTR_BITS > 4) || (GHR_BITS > IDX_BITS) || (GHR_BITS < 1)) begin : g_bad_cfg
    $error("branch_predictor: illegal parameter combination");
  end

  logic                tbl_valid [ENTRIES];
  logic [TAG_BITS-1:0] tbl_tag   [ENTRIES];
  logic [TGT_W-1:0]    tbl_tgt   [ENTRIES];
  logic [CTR_BITS-1:0] tbl_ctr   [ENTRIES];

  logic [IDX_BITS-1:0] hist;
  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic                lk_hit;
  logic [IDX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0] up_tag;
  logic                up_hit;
  logic                up_alloc;

  logic                id_hit_p1;
  logic                id_taken_p1;
  logic [31:0]         id_tgt_p1;

  logic                unused_tgt_lsbs;
  assign unused_tgt_lsbs = ^ex_upd_target[1:0];

`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr;

  // History advances after this cycle's lookup and update have used it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr <= '0;
    end else if (ex_upd_valid) begin
      ghr <= GHR_BITS'({ghr, ex_upd_taken});
    end
  end

  assign hist = IDX_BITS'(ghr);
`else
  assign hist = '0;
`endif

  assign lk_idx = IDX_BITS'(pc_index(if_pc, IDX_BITS)) ^ hist;
  assign lk_tag = TAG_BITS'(pc_tag(if_pc, IDX_BITS, TAG_BITS));
  assign lk_hit = tbl_valid[lk_idx] && (tbl_tag[lk_idx] == lk_tag);

  assign up_idx   = IDX_BITS'(pc_index(ex_upd_pc, IDX_BITS)) ^ hist;
  assign up_tag   = TAG_BITS'(pc_tag(ex_upd_pc, IDX_BITS, TAG_BITS));
  assign up_hit   = tbl_valid[up_idx] && (tbl_tag[up_idx] == up_tag);
  assign up_alloc = ex_upd_valid && !up_hit && ex_upd_taken;

  // ---- IF -> ID boundary: lookup reads pre-update table contents ----
  always_ff @(posedge clk) begin
    if (rst) begin
      id_hit_p1   <= 1'b0;
      id_taken_p1 <= 1'b0;
      id_tgt_p1   <= '0;
    end else if (!if_stall) begin
      id_hit_p1   <= lk_hit;
      id_taken_p1 <= lk_hit && tbl_ctr[lk_idx][CTR_BITS-1] && bp_enable;
      id_tgt_p1   <= lk_hit ? {tbl_tgt[lk_idx], 2'b00} : '0;
    end
  end

  assign id_pred_hit    = id_hit_p1;
  assign id_pred_taken  = id_taken_p1;
  assign id_pred_target = id_tgt_p1;

  // ---- EX training: valid bits are control, tag/target are data ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_valid[i] <= 1'b0;
      end
    end else if (up_alloc) begin
      tbl_valid[up_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ex_upd_valid && ex_upd_taken) begin
      if (!up_hit) begin
        tbl_tag[up_idx] <= up_tag;
      end
      tbl_tgt[up_idx] <= ex_upd_target[31:2];
    end
  end

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ctr
    logic sel;
    assign sel = ex_upd_valid && (up_idx == IDX_BITS'(e));

    bp_sat_counter #(
      .CTR_BITS (CTR_BITS)
    ) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .load  (sel && !up_hit && ex_upd_taken),
      .inc   (sel && up_hit && ex_upd_taken),
      .dec   (sel && up_hit && !ex_upd_taken),
      .count (tbl_ctr[e])
    );
  end

  // Statistics ignore bp_enable and if_stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches <= '0;
      stat_mispreds <= '0;
    end else if (ex_upd_valid) begin
      stat_branches <= stat_branches + 32'd1;
      if (ex_upd_mispred) begin
        stat_mispreds <= stat_mispreds + 32'd1;
      end
    end
  end

endmodule
